alu_share_ctrl: RTL and testbench

- Sequencer and arbiter that shares the single 4-bit, 8-operation ALU between two requesters.
  - Requester 0: the button/switch front end.
  - Requester 1: an automatic self-test driver.
- Accepts one command per handshake and drives the ALU opcode, operands and enable.
- Waits a programmable settle time, then captures result and flags.
- Returns the captured values on a response channel tagged with the requester ID.

---
 rtl/alu_share_ctrl_if.sv | 29 ++
 rtl/alu_share_ctrl.sv | 103 ++++++++++
 tb/tb_alu_share_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: requester, ALU and response channels of alu_share_ctrl.
// master = environment side (requesters, ALU, consumer), slave = the controller.
interface alu_share_ctrl_if;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0] req0_op, req1_op, alu_op;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       alu_en;
   logic [3:0] alu_a, alu_b, alu_result, alu_flags;
   logic       rsp_valid, rsp_id, rsp_ready;
   logic [3:0] rsp_result, rsp_flags;
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  alu_en, alu_op, alu_a, alu_b,
      output alu_result, alu_flags,
      input  rsp_valid, rsp_id, rsp_result, rsp_flags,
      output rsp_ready
   );
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req0_ready, req1_ready,
      output alu_en, alu_op, alu_a, alu_b,
      input  alu_result, alu_flags,
      output rsp_valid, rsp_id, rsp_result, rsp_flags,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: two-requester arbiter/sequencer for a shared 4-bit ALU.
// Optional grant counters (gnt0_cnt/gnt1_cnt) when ALU_SHARE_STATS_EN is defined.
module alu_share_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input logic clk,
   input logic rst,
   alu_share_ctrl_if.slave ctrl_io
`ifdef ALU_SHARE_STATS_EN
   ,
   output logic [7:0] gnt0_cnt,
   output logic [7:0] gnt1_cnt
`endif
);
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);
   logic [1:0] state_q, state_d;
   logic       ptr_q, ptr_d, id_q, id_d;
   logic [3:0] cnt_q, cnt_d;
   logic       alu_en_q, alu_en_d;
   logic [2:0] op_q, op_d;
   logic [3:0] a_q, a_d, b_q, b_d;
   logic       rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
   logic [3:0] res_q, res_d, flg_q, flg_d;
   logic       gnt0, gnt1, hs, done, ack;
   // Tie-break goes to the pointer; a lone valid always wins.
   assign gnt0 = (state_q == IDLE) & ctrl_io.req0_valid & (~ctrl_io.req1_valid | ~ptr_q);
   assign gnt1 = (state_q == IDLE) & ctrl_io.req1_valid & (~ctrl_io.req0_valid | ptr_q);
   assign hs   = gnt0 | gnt1;
   assign done = (state_q == WAIT) && (cnt_q == 4'd0);
   assign ack  = (state_q == RESP) && rsp_valid_q && ctrl_io.rsp_ready;
   always_comb begin
      state_d     = hs ? WAIT : done ? RESP : ack ? IDLE : state_q;
      id_d        = hs ? gnt1 : id_q;
      op_d        = hs ? (gnt1 ? ctrl_io.req1_op : ctrl_io.req0_op) : op_q;
      a_d         = hs ? (gnt1 ? ctrl_io.req1_a : ctrl_io.req0_a) : a_q;
      b_d         = hs ? (gnt1 ? ctrl_io.req1_b : ctrl_io.req0_b) : b_q;
      alu_en_d    = hs ? 1'b1 : done ? 1'b0 : alu_en_q;
      cnt_d       = hs ? SETTLE_LD : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      rsp_valid_d = done ? 1'b1 : ack ? 1'b0 : rsp_valid_q;
      rsp_id_d    = done ? id_q : rsp_id_q;
      res_d       = done ? ctrl_io.alu_result : res_q;
      flg_d       = done ? ctrl_io.alu_flags : flg_q;
      ptr_d       = ack ? ~rsp_id_q : ptr_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         id_q        <= 1'b0;
         cnt_q       <= 4'd0;
         alu_en_q    <= 1'b0;
         op_q        <= 3'd0;
         a_q         <= 4'd0;
         b_q         <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         res_q       <= 4'd0;
         flg_q       <= 4'd0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         alu_en_q    <= alu_en_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         res_q       <= res_d;
         flg_q       <= flg_d;
      end
   end
   assign ctrl_io.req0_ready = gnt0;
   assign ctrl_io.req1_ready = gnt1;
   assign ctrl_io.alu_en     = alu_en_q;
   assign ctrl_io.alu_op     = op_q;
   assign ctrl_io.alu_a      = a_q;
   assign ctrl_io.alu_b      = b_q;
   assign ctrl_io.rsp_valid  = rsp_valid_q;
   assign ctrl_io.rsp_id     = rsp_id_q;
   assign ctrl_io.rsp_result = res_q;
   assign ctrl_io.rsp_flags  = flg_q;
`ifdef ALU_SHARE_STATS_EN
   logic [7:0] g0_q, g0_d, g1_q, g1_d;
   always_comb begin
      g0_d = (gnt0 && g0_q != 8'hFF) ? g0_q + 8'd1 : g0_q;
      g1_d = (gnt1 && g1_q != 8'hFF) ? g1_q + 8'd1 : g1_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         g0_q <= 8'd0;
         g1_q <= 8'd0;
      end else begin
         g0_q <= g0_d;
         g1_q <= g1_d;
      end
   end
   assign gnt0_cnt = g0_q;
   assign gnt1_cnt = g1_q;
`endif
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed vectors for alu_share_ctrl with a small ALU model.
module tb_alu_share_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vecs = 0;
   int   miss = 0;
   int   t;
   alu_share_ctrl_if bus ();
`ifdef ALU_SHARE_STATS_EN
   logic [7:0] gnt0_cnt, gnt1_cnt;
`endif
   alu_share_ctrl #(.SETTLE_CYCLES(1)) dut (
      .clk(clk),
      .rst(rst),
      .ctrl_io(bus)
`ifdef ALU_SHARE_STATS_EN
      ,
      .gnt0_cnt(gnt0_cnt),
      .gnt1_cnt(gnt1_cnt)
`endif
   );
   always #5 clk = ~clk;
   // Shared ALU: outputs read zero while disabled.
   logic [4:0] s5;
   logic [3:0] r;
   logic       cf, ov;
   always_comb begin
      s5 = (bus.alu_op == 3'd1) ? {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1
                                : {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      r  = (bus.alu_op <= 3'd1) ? s5[3:0] :
           (bus.alu_op == 3'd2) ? ~bus.alu_a :
           (bus.alu_op == 3'd3) ? bus.alu_a & bus.alu_b :
           (bus.alu_op == 3'd4) ? bus.alu_a | bus.alu_b :
           (bus.alu_op == 3'd5) ? bus.alu_a ^ bus.alu_b :
           (bus.alu_op == 3'd6) ? {3'd0, bus.alu_a < bus.alu_b} : {3'd0, bus.alu_a == bus.alu_b};
      cf = (bus.alu_op <= 3'd1) ? s5[4] : 1'b0;
      ov = (bus.alu_op == 3'd0) ? (bus.alu_a[3] == bus.alu_b[3]) && (r[3] != bus.alu_a[3]) :
           (bus.alu_op == 3'd1) ? (bus.alu_a[3] != bus.alu_b[3]) && (r[3] != bus.alu_a[3]) : 1'b0;
   end
   assign bus.alu_result = bus.alu_en ? r : 4'd0;
   assign bus.alu_flags  = bus.alu_en ? {cf, r == 4'd0, r[3], ov} : 4'd0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vecs++;
      if (got !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_reqs();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask
   task automatic set_req(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end
   endtask
   // One full command with rsp_ready high; starts and ends in IDLE just after an edge.
   task automatic run_cmd(input logic id, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] res, input logic [3:0] flg);
      set_req(id, op, a, b);
      #1;
      chk("req0_ready", 8'(bus.req0_ready), 8'(!id));
      chk("req1_ready", 8'(bus.req1_ready), 8'(id));
      step();
      idle_reqs();
      chk("alu_en_on", 8'(bus.alu_en), 8'd1);
      chk("alu_op", 8'(bus.alu_op), 8'(op));
      chk("alu_a", 8'(bus.alu_a), 8'(a));
      chk("alu_b", 8'(bus.alu_b), 8'(b));
      chk("rsp_early", 8'(bus.rsp_valid), 8'd0);
      step();
      chk("alu_en_off", 8'(bus.alu_en), 8'd0);
      chk("rsp_valid", 8'(bus.rsp_valid), 8'd1);
      chk("rsp_id", 8'(bus.rsp_id), 8'(id));
      chk("rsp_result", 8'(bus.rsp_result), 8'(res));
      chk("rsp_flags", 8'(bus.rsp_flags), 8'(flg));
      step();
      chk("rsp_clear", 8'(bus.rsp_valid), 8'd0);
      chk("rsp_hold", 8'(bus.rsp_result), 8'(res));
   endtask

   initial begin
      idle_reqs();
      bus.req0_op = 3'd0; bus.req0_a = 4'd0; bus.req0_b = 4'd0;
      bus.req1_op = 3'd0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
      bus.rsp_ready = 1'b1;
      step();
      step();
      #2 rst = 1'b0;
      chk("rst_alu_en", 8'(bus.alu_en), 8'd0);
      chk("rst_alu_op", 8'(bus.alu_op), 8'd0);
      chk("rst_alu_ab", {bus.alu_a, bus.alu_b}, 8'd0);
      chk("rst_rsp_valid", 8'(bus.rsp_valid), 8'd0);
      chk("rst_rsp_id", 8'(bus.rsp_id), 8'd0);
      chk("rst_rsp_data", {bus.rsp_result, bus.rsp_flags}, 8'd0);
      chk("rst_ready", {6'd0, bus.req1_ready, bus.req0_ready}, 8'd0);
      step();
      run_cmd(1'b0, 3'd0, 4'd3, 4'd4, 4'h7, 4'h0);
      run_cmd(1'b0, 3'd1, 4'd5, 4'd5, 4'h0, 4'hC);
      run_cmd(1'b1, 3'd5, 4'hA, 4'h6, 4'hC, 4'h2);
      run_cmd(1'b0, 3'd0, 4'd7, 4'd1, 4'h8, 4'h3);
      run_cmd(1'b1, 3'd6, 4'd2, 4'd9, 4'h1, 4'h0);
      // Both requesters held from reset: grants must alternate 0,1,0,1.
      rst = 1'b1;
      #2 rst = 1'b0;
      step();
      set_req(1'b0, 3'd0, 4'd1, 4'd1);
      set_req(1'b1, 3'd3, 4'hF, 4'h5);
      #1;
      for (int n = 0; n < 4; n++) begin
         t = 0;
         while (!(bus.req0_ready | bus.req1_ready) && t < 10) begin step(); t++; end
         chk("gnt_seen", 8'(t < 10), 8'd1);
         chk("gnt_order", 8'(bus.req1_ready), 8'(n % 2));
         chk("gnt_single", 8'(bus.req0_ready & bus.req1_ready), 8'd0);
         step();
         t = 0;
         while (!bus.rsp_valid && t < 10) begin step(); t++; end
         chk("rsp_seen", 8'(t < 10), 8'd1);
         chk("rsp_id_alt", 8'(bus.rsp_id), 8'(n % 2));
         chk("rsp_res_alt", 8'(bus.rsp_result), (n % 2 == 1) ? 8'h5 : 8'h2);
         step();
      end
      // Back-pressure: response held for 5 cycles, no grants meanwhile.
      bus.req1_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      #1;
      chk("bp_gnt", 8'(bus.req0_ready), 8'd1);
      step();
      bus.req1_valid = 1'b1;
      step();
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", 8'(bus.rsp_valid), 8'd1);
         chk("bp_data", {bus.rsp_result, bus.rsp_flags}, 8'h20);
         chk("bp_id", 8'(bus.rsp_id), 8'd0);
         chk("bp_no_gnt", {6'd0, bus.req1_ready, bus.req0_ready}, 8'd0);
         step();
      end
      bus.rsp_ready = 1'b1;
      step();
      chk("bp_release", 8'(bus.rsp_valid), 8'd0);
      chk("bp_next_gnt", {6'd0, bus.req1_ready, bus.req0_ready}, 8'd2);
      idle_reqs();
      #1;
      // Reset in WAIT with the pointer at 1: command dropped, pointer back to 0.
      set_req(1'b0, 3'd0, 4'd3, 4'd4);
      #1;
      step();
      idle_reqs();
      chk("wait_en", 8'(bus.alu_en), 8'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_en", 8'(bus.alu_en), 8'd0);
      chk("mid_rst_ab", {bus.alu_a, bus.alu_b}, 8'd0);
      chk("mid_rst_rsp", {3'd0, bus.rsp_valid, bus.rsp_result}, 8'd0);
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("dropped_rsp", 8'(bus.rsp_valid), 8'd0);
      end
      set_req(1'b0, 3'd0, 4'd0, 4'd0);
      set_req(1'b1, 3'd0, 4'd0, 4'd0);
      #1;
      chk("ptr_reset", {6'd0, bus.req1_ready, bus.req0_ready}, 8'd1);
      idle_reqs();
      #1;
`ifdef ALU_SHARE_STATS_EN
      rst = 1'b1;
      #2 rst = 1'b0;
      step();
      bus.req1_valid = 1'b1;
      for (int k = 0; k < 900; k++) step();
      idle_reqs();
      chk("gnt1_cnt_sat", gnt1_cnt, 8'hFF);
      chk("gnt0_cnt_zero", gnt0_cnt, 8'h00);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
